// File: rtl/grid_gate_pkg.sv
// Shared types and constants for the grid gate drive: leg commands, leg states
// and the legal sector range.
package grid_gate_pkg;

  typedef enum logic [1:0] {
    CMD_OFF = 2'd0,
    CMD_HI  = 2'd1,
    CMD_LO  = 2'd2
  } leg_cmd_e;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_DEAD = 2'd3
  } leg_state_e;

  localparam logic [15:0] SECT_MIN = 16'd1;
  localparam logic [15:0] SECT_MAX = 16'd6;

  function automatic logic sector_valid(input logic [15:0] sect);
    return (sect >= SECT_MIN) && (sect <= SECT_MAX);
  endfunction

endpackage

// File: rtl/grid_deadband_leg.sv
// One bridge leg: OFF/HI/LO/DEAD state machine with dead-time counter and a
// registered, mutually exclusive high/low gate pair.
module grid_deadband_leg
  import grid_gate_pkg::*;
#(
  parameter int DEAD_CYC = 50,
  parameter int DT_W     = 8
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  leg_cmd_e i_cmd,
  input  logic     i_force_off,
  output logic     o_gate_h,
  output logic     o_gate_l
);

  localparam logic [DT_W-1:0] LP_DEAD_LOAD = DT_W'(DEAD_CYC - 1);

  leg_state_e      r_state;
  leg_state_e      w_nxt_state;
  logic [DT_W-1:0] r_cnt;
  logic [DT_W-1:0] w_nxt_cnt;
  logic            r_gate_h;
  logic            r_gate_l;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_OFF;
      r_cnt    <= '0;
      r_gate_h <= 1'b0;
      r_gate_l <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_cnt    <= w_nxt_cnt;
      r_gate_h <= (w_nxt_state == ST_HI);
      r_gate_l <= (w_nxt_state == ST_LO);
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    if (i_force_off) begin
      // Forced turn-off abandons any dead-time in progress.
      w_nxt_state = ST_OFF;
      w_nxt_cnt   = '0;
    end else begin
      unique case (r_state)
        ST_OFF: begin
          if (i_cmd == CMD_HI)      w_nxt_state = ST_HI;
          else if (i_cmd == CMD_LO) w_nxt_state = ST_LO;
        end
        ST_HI: begin
          if (i_cmd == CMD_OFF) begin
            w_nxt_state = ST_OFF;
          end else if (i_cmd == CMD_LO) begin
            w_nxt_state = ST_DEAD;
            w_nxt_cnt   = LP_DEAD_LOAD;
          end
        end
        ST_LO: begin
          if (i_cmd == CMD_OFF) begin
            w_nxt_state = ST_OFF;
          end else if (i_cmd == CMD_HI) begin
            w_nxt_state = ST_DEAD;
            w_nxt_cnt   = LP_DEAD_LOAD;
          end
        end
        ST_DEAD: begin
          // Dead-time always completes; the command only picks the exit state.
          if (r_cnt == '0) begin
            unique case (i_cmd)
              CMD_HI:  w_nxt_state = ST_HI;
              CMD_LO:  w_nxt_state = ST_LO;
              default: w_nxt_state = ST_OFF;
            endcase
          end else begin
            w_nxt_cnt = r_cnt - DT_W'(1);
          end
        end
        default: w_nxt_state = ST_OFF;
      endcase
    end
  end

  assign o_gate_h = r_gate_h;
  assign o_gate_l = r_gate_l;

endmodule

// File: rtl/grid_gate_drive.sv
// Six-gate bridge driver: sector decode into leg commands, latched fault trip
// with period-aligned re-arm, and three dead-time legs.
module grid_gate_drive
  import grid_gate_pkg::*;
#(
  parameter int DEAD_CYC = 50,
  parameter int DT_W     = 8
) (
  input  logic        sysclk,
  input  logic        global_rst,
  input  logic        grid_judge,
  input  logic [15:0] grid_sector_shadow,
  input  logic [15:0] global_cnt_rising,
  input  logic        pwm_en,
  input  logic        fault_in,
  input  logic        fault_clr,
  output logic        gate_ah,
  output logic        gate_al,
  output logic        gate_bh,
  output logic        gate_bl,
  output logic        gate_ch,
  output logic        gate_cl,
  output logic        trip_flag,
  output logic        sector_err
);

  leg_cmd_e w_cmd_a;
  leg_cmd_e w_cmd_b;
  leg_cmd_e w_cmd_c;
  leg_cmd_e w_pwm_cmd;
  logic     w_period_start;
  logic     w_force_off;
  logic     r_trip;
  logic     r_rearm_wait;
  logic     r_sector_err;

  assign w_pwm_cmd      = grid_judge ? CMD_LO : CMD_HI;
  assign w_period_start = (global_cnt_rising == 16'd0);

  always_comb begin
    w_cmd_a = CMD_OFF;
    w_cmd_b = CMD_OFF;
    w_cmd_c = CMD_OFF;
    unique case (grid_sector_shadow)
      16'd1: begin w_cmd_a = w_pwm_cmd; w_cmd_b = CMD_LO; end
      16'd2: begin w_cmd_a = w_pwm_cmd; w_cmd_c = CMD_LO; end
      16'd3: begin w_cmd_b = w_pwm_cmd; w_cmd_c = CMD_LO; end
      16'd4: begin w_cmd_b = w_pwm_cmd; w_cmd_a = CMD_LO; end
      16'd5: begin w_cmd_c = w_pwm_cmd; w_cmd_a = CMD_LO; end
      16'd6: begin w_cmd_c = w_pwm_cmd; w_cmd_b = CMD_LO; end
      default: ;
    endcase
  end

  // A raw fault forces the legs off on the same edge that latches the trip.
  assign w_force_off = !pwm_en || r_trip || fault_in ||
                       (r_rearm_wait && !w_period_start);

  always_ff @(posedge sysclk or posedge global_rst) begin
    if (global_rst) begin
      r_trip       <= 1'b0;
      r_rearm_wait <= 1'b0;
      r_sector_err <= 1'b0;
    end else begin
      r_sector_err <= !sector_valid(grid_sector_shadow);
      if (fault_in) begin
        r_trip <= 1'b1;
      end else if (fault_clr && r_trip) begin
        r_trip       <= 1'b0;
        r_rearm_wait <= 1'b1;
      end else if (w_period_start) begin
        r_rearm_wait <= 1'b0;
      end
    end
  end

  grid_deadband_leg #(.DEAD_CYC(DEAD_CYC), .DT_W(DT_W)) u_leg_a (
    .i_clk       (sysclk),
    .i_rst       (global_rst),
    .i_cmd       (w_cmd_a),
    .i_force_off (w_force_off),
    .o_gate_h    (gate_ah),
    .o_gate_l    (gate_al)
  );

  grid_deadband_leg #(.DEAD_CYC(DEAD_CYC), .DT_W(DT_W)) u_leg_b (
    .i_clk       (sysclk),
    .i_rst       (global_rst),
    .i_cmd       (w_cmd_b),
    .i_force_off (w_force_off),
    .o_gate_h    (gate_bh),
    .o_gate_l    (gate_bl)
  );

  grid_deadband_leg #(.DEAD_CYC(DEAD_CYC), .DT_W(DT_W)) u_leg_c (
    .i_clk       (sysclk),
    .i_rst       (global_rst),
    .i_cmd       (w_cmd_c),
    .i_force_off (w_force_off),
    .o_gate_h    (gate_ch),
    .o_gate_l    (gate_cl)
  );

  assign trip_flag  = r_trip;
  assign sector_err = r_sector_err;

endmodule

// File: doc/grid_gate_drive.md
# grid_gate_drive

Downstream stage of the grid duty comparator. Converts the per-period compare result `grid_judge` and the shadowed sector `grid_sector_shadow` into six bridge gate signals. Each leg has its own dead-time insertion and there is a latched fault trip. It sits between the PWM compare logic and the gate-driver pins; all outputs are registered.

## Interface
Parameters:
- `DEAD_CYC`, default 50: dead-time length in sysclk cycles; legal range 1 .. 2^DT_W−1.
- `DT_W`, default 8: width of the dead-time counter.

Ports:
- `sysclk` input 1: system clock; every register is clocked on its rising edge.
- `global_rst` input 1: asynchronous, active-high reset.
- `grid_judge` input 1: compare result; 0 = active (high-side) region, 1 = inactive region.
- `grid_sector_shadow` input 16: sector, valid values 1..6, changes only at period start.
- `global_cnt_rising` input 16: carrier count; value 0 marks period start.
- `pwm_en` input 1: 1 = drive enabled.
- `fault_in` input 1: hardware fault, active high, level.
- `fault_clr` input 1: single-cycle request to clear a latched trip.
- `gate_ah`, `gate_al`, `gate_bh`, `gate_bl`, `gate_ch`, `gate_cl` output 1 each: gate drives, 1 = switch on.
- `trip_flag` output 1: latched fault indication.
- `sector_err` output 1: 1 while the sector value is outside 1..6.

## Operation
- Sector-to-leg command mapping. "PWM" means HI when `grid_judge`=0 and LO when `grid_judge`=1. "LO" means the low side is held on. The remaining leg is OFF.
  - Sector 1: A=PWM, B=LO, C=OFF
  - Sector 2: A=PWM, C=LO, B=OFF
  - Sector 3: B=PWM, C=LO, A=OFF
  - Sector 4: B=PWM, A=LO, C=OFF
  - Sector 5: C=PWM, A=LO, B=OFF
  - Sector 6: C=PWM, B=LO, A=OFF
  - Sector 0 or >6: all legs OFF, and `sector_err`=1 on the next edge.
- Per-leg FSM, states OFF, HI, LO, DEAD:
  - OFF → HI or LO directly when commanded.
  - HI or LO → OFF directly. Turn-off is always immediate.
  - HI → LO or LO → HI goes through DEAD. On entry to DEAD, the counter loads DEAD_CYC−1.
  - In DEAD, the counter decrements. When it reaches 0, the leg enters the command present at that edge (HI, LO or OFF).
  - DEAD always runs to completion. A command change during DEAD only changes the exit target.
- Gate outputs: HI gives h=1, l=0. LO gives h=0, l=1. OFF and DEAD give 0, 0. h and l of one leg are never 1 simultaneously, in any state.
- Force-off: when `pwm_en`=0 or `trip_flag`=1, all three legs go to OFF on the next edge, including from DEAD, whose counter is discarded.
- Trip behaviour:
  - `fault_in`=1 sets `trip_flag` on the next edge.
  - `fault_clr`=1 with `fault_in`=0 clears `trip_flag`.
  - If `fault_clr` and `fault_in` are asserted together, set wins.
  - After a clear, legs stay OFF until the first edge with `global_cnt_rising`==0. Track this with an internal `rearm_wait` flag.

## Timing
- Reset values: all gates 0, `trip_flag`=0, `sector_err`=0, all legs OFF, counters 0, `rearm_wait`=0.
- Latency from input change (sampled at edge k) to gate output:
  - OFF→HI/LO and anything→OFF: visible after edge k.
  - HI↔LO: both gates are 0 for exactly DEAD_CYC cycles after edge k; the new side turns on at edge k+DEAD_CYC.
- Fault path: from `fault_in` assertion, all gates are 0 after one edge.
- A sector change at period start re-maps commands on the same edge. The per-leg rules still apply, so a leg going from LO to PWM-HI passes through DEAD.
- Reset asserted mid-DEAD: gates go to 0 immediately (asynchronously) and the leg returns to OFF.

## Structure
- Shared package `grid_gate_pkg` holds:
  - leg command enum (CMD_OFF, CMD_HI, CMD_LO)
  - leg state enum (ST_OFF, ST_HI, ST_LO, ST_DEAD)
  - sector constants SECT_MIN=1 and SECT_MAX=6
- Sub-module `grid_deadband_leg`: one leg's FSM, counter and gate pair. It is instantiated three times.
- The top level holds the sector decode, trip latch and re-arm logic.

## Test plan
All scenarios use DEAD_CYC=4.
- Reset release, sector 1, `pwm_en`=1, `grid_judge`=0 → `gate_ah`=1 and `gate_bl`=1 after one edge; all other gates 0.
- Sector 1, `grid_judge` 0→1 → `gate_ah` falls after one edge; `gate_al` stays 0 for 4 cycles, then rises. With the reverse transition, `gate_ah` rises 4 cycles after `gate_al` falls.
- `grid_judge` toggles again during DEAD → DEAD still lasts exactly 4 cycles; the exit state follows the final command. Checker asserts h&l never 1 on any leg.
- `fault_in` pulse while legs are HI/LO → all gates 0 next edge, `trip_flag`=1. `fault_clr` at count 500 → flag clears, gates stay 0 until `global_cnt_rising`==0, then the mapping resumes.
- Sector 7 → all gates 0, `sector_err`=1. Sector 3 at the next period start → `gate_bh`/`gate_cl` active, `sector_err`=0.
- Sector 1→2 at period start → leg B goes LO→OFF immediately and leg C goes OFF→LO next edge. Reset asserted mid-DEAD → all outputs 0 asynchronously.
